axis_pkt_fifo: RTL and testbench
================================

AXIS_PKT_FIFO -- requirements
Module: axis_pkt_fifo

Interface
REQ-001 Parameter WIDTH, default 8, meaning TDATA width in bits (>=1).
REQ-002 Parameter DEPTH, default 16, meaning storage entries (power of 2, >=2).
REQ-003 Parameter PKT_MODE, default 0, meaning 0=cut-through, 1=store-and-forward per TLAST packet.
REQ-004 clk  input  1  single clock for the block; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 S_AXIS_TVALID  input  1  upstream beat valid.
REQ-007 S_AXIS_TREADY  output  1  FIFO can accept a beat.
REQ-008 S_AXIS_TDATA  input  WIDTH  upstream data.
REQ-009 S_AXIS_TLAST  input  1  upstream end-of-packet.
REQ-010 M_AXIS_TVALID  output  1  downstream beat valid.
REQ-011 M_AXIS_TREADY  input  1  downstream ready.
REQ-012 M_AXIS_TDATA  output  WIDTH  downstream data.
REQ-013 M_AXIS_TLAST  output  1  downstream end-of-packet.
REQ-014 level  output  $clog2(DEPTH)+1  entries currently stored.
REQ-015 pkt_count  output  $clog2(DEPTH)+1  complete packets (TLAST stored) currently held.
REQ-016 oversize_err  output  1  sticky flag: packet exceeded DEPTH in PKT_MODE=1.

Function
REQ-017 Write beat = S_AXIS_TVALID & S_AXIS_TREADY; read beat = M_AXIS_TVALID & M_AXIS_TREADY; each transfers exactly one entry {TLAST,TDATA}.
REQ-018 S_AXIS_TREADY SHALL be high iff level < DEPTH, independent of S_AXIS_TVALID and M_AXIS_TREADY.
REQ-019 Full with simultaneous read: no write accepted that cycle (no same-cycle pass-through); TREADY rises the cycle after the read.
REQ-020 Read/write pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-021 level SHALL increment on write-only, decrement on read-only, hold on both or neither; never exceeds DEPTH or underflows.
REQ-022 M_AXIS_TDATA/TLAST SHALL present entry at read pointer combinationally whenever M_AXIS_TVALID is high and hold stable until the read beat.
REQ-023 PKT_MODE=0: M_AXIS_TVALID = (level != 0); first beat written at edge N visible as valid in cycle N+1.
REQ-024 PKT_MODE=1: M_AXIS_TVALID = (level != 0) & (pkt_count != 0 | flush); first beat of a packet becomes valid the cycle after its TLAST beat is written.
REQ-025 pkt_count SHALL increment on write beat with TLAST=1, decrement on read beat with TLAST=1, hold if both same cycle.
REQ-026 PKT_MODE=1, level==DEPTH with pkt_count==0: SHALL set flush and oversize_err; flush releases beats cut-through until a read beat with TLAST=1 clears flush.
REQ-027 oversize_err SHALL stay set until reset; PKT_MODE=0 ties it to 0.
REQ-028 Once M_AXIS_TVALID is high it SHALL not deassert before the read beat (AXI-Stream stability).

Reset
REQ-029 While rst=1 at a rising edge: pointers, level, pkt_count, flush, oversize_err SHALL clear to 0.
REQ-030 Outputs the cycle after reset: S_AXIS_TREADY=1, M_AXIS_TVALID=0, level=0, pkt_count=0, oversize_err=0; M_AXIS_TDATA/TLAST don't-care.
REQ-031 Reset mid-packet SHALL discard all stored and partial data; no beat from before reset appears afterward.
REQ-032 Storage array SHALL not be reset.

Structure
REQ-033 Package axis_fifo_pkg SHALL hold default WIDTH/DEPTH/PKT_MODE constants and the entry struct {tlast, tdata}.
REQ-034 Storage SHALL be sub-module axis_fifo_ram (1 write port, 1 async read port, DEPTH x (WIDTH+1)); control stays in axis_pkt_fifo.

Verification
REQ-035 PKT_MODE=0, DEPTH=16: write 0x01..0x05 with M_AXIS_TREADY=0 -> level=5, TVALID high from cycle after first write; then ready=1 -> 0x01..0x05 out in order, level=0.
REQ-036 Fill 16 beats, ready=0 -> S_AXIS_TREADY=0, level=16; assert ready and TVALID same cycle -> 17th beat not accepted that cycle, accepted next.
REQ-037 Continuous write+read over 40 beats, DEPTH=16 -> pointers wrap twice, data order intact, level constant.
REQ-038 PKT_MODE=1: write 3 beats, TLAST on beat 3, ready=1 -> TVALID low until cycle after beat 3 accepted; pkt_count 0->1->0.
REQ-039 PKT_MODE=1, DEPTH=8: 10-beat packet -> at level 8 oversize_err=1, flush drains beats 0..9 in order, flush clears after TLAST read.
REQ-040 Assert rst after 4 beats of 6-beat packet -> level=0, TVALID=0, TREADY=1 next cycle; new packet 0xA0..0xA2 emerges alone.

Source files
------------

// File: rtl/axis_fifo_pkg.sv
// axis_fifo_pkg
//   Shared defaults and entry layout for the AXI-Stream packet FIFO.
//   AXIS_FIFO_WIDTH    : default TDATA width in bits
//   AXIS_FIFO_DEPTH    : default number of storage entries (power of 2)
//   AXIS_FIFO_PKT_MODE : default mode, 0 = cut-through, 1 = store-and-forward
//   axis_entry_t       : one stored beat {tlast, tdata} at the default width;
//                        the FIFO packs non-default widths in the same order.
package axis_fifo_pkg;

    localparam int unsigned AXIS_FIFO_WIDTH    = 8;
    localparam int unsigned AXIS_FIFO_DEPTH    = 16;
    localparam int unsigned AXIS_FIFO_PKT_MODE = 0;

    typedef struct packed {
        logic                       tlast;
        logic [AXIS_FIFO_WIDTH-1:0] tdata;
    } axis_entry_t;

endpackage

// File: rtl/axis_fifo_ram.sv
// axis_fifo_ram
//   DEPTH x (WIDTH+1) storage, one synchronous write port and one
//   asynchronous read port. Contents are deliberately not reset.
//   clk     : write clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data {tlast, tdata}
//   raddr_i : read address
//   rdata_o : read data {tlast, tdata}, combinational from raddr_i
module axis_fifo_ram
    import axis_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = AXIS_FIFO_WIDTH,
    parameter int unsigned DEPTH = AXIS_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH:0]           wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH:0]           rdata_o
);

    logic [WIDTH:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axis_pkt_fifo.sv
// axis_pkt_fifo
//   AXI-Stream FIFO with optional store-and-forward packet mode.
//   clk, rst                 : clock, synchronous active-high reset
//   S_AXIS_TVALID/TREADY     : upstream handshake
//   S_AXIS_TDATA/TLAST       : upstream beat
//   M_AXIS_TVALID/TREADY     : downstream handshake
//   M_AXIS_TDATA/TLAST       : downstream beat (entry at read pointer)
//   level                    : entries currently stored
//   pkt_count                : complete packets (TLAST stored) held
//   oversize_err             : sticky, a packet did not fit in packet mode
module axis_pkt_fifo
    import axis_fifo_pkg::*;
#(
    parameter int unsigned WIDTH    = AXIS_FIFO_WIDTH,
    parameter int unsigned DEPTH    = AXIS_FIFO_DEPTH,
    parameter int unsigned PKT_MODE = AXIS_FIFO_PKT_MODE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     S_AXIS_TVALID,
    output logic                     S_AXIS_TREADY,
    input  logic [WIDTH-1:0]         S_AXIS_TDATA,
    input  logic                     S_AXIS_TLAST,
    output logic                     M_AXIS_TVALID,
    input  logic                     M_AXIS_TREADY,
    output logic [WIDTH-1:0]         M_AXIS_TDATA,
    output logic                     M_AXIS_TLAST,
    output logic [$clog2(DEPTH):0]   level,
    output logic [$clog2(DEPTH):0]   pkt_count,
    output logic                     oversize_err
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic [AW:0]   pkt_q, pkt_d;
    logic          flush_q, flush_d;
    logic          ovf_q, ovf_d;

    logic          full;
    logic          wr_en;
    logic          rd_en;
    logic [WIDTH:0] rd_entry;

    axis_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i ({S_AXIS_TLAST, S_AXIS_TDATA}),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

    // Ready depends only on stored level, so a read while full cannot
    // make room for a write in the same cycle.
    assign full          = (level_q == FULL_LVL);
    assign S_AXIS_TREADY = ~full;
    assign wr_en         = S_AXIS_TVALID & ~full;

    // In packet mode a beat is only offered once its packet is complete,
    // or once an oversize packet forced a cut-through flush.
    assign M_AXIS_TVALID = (level_q != '0) &&
                           ((PKT_MODE == 0) || (pkt_q != '0) || flush_q);
    assign rd_en         = M_AXIS_TVALID & M_AXIS_TREADY;

    assign M_AXIS_TDATA  = rd_entry[WIDTH-1:0];
    assign M_AXIS_TLAST  = rd_entry[WIDTH];
    assign level         = level_q;
    assign pkt_count     = pkt_q;
    assign oversize_err  = ovf_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        pkt_d    = pkt_q;
        flush_d  = flush_q;
        ovf_d    = ovf_q;

        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;

        case ({wr_en, rd_en})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        case ({wr_en & S_AXIS_TLAST, rd_en & M_AXIS_TLAST})
            2'b10:   pkt_d = pkt_q + 1'b1;
            2'b01:   pkt_d = pkt_q - 1'b1;
            default: pkt_d = pkt_q;
        endcase

        if (rd_en && M_AXIS_TLAST) flush_d = 1'b0;

        // Full with no complete packet can never make progress on its own:
        // release the stored beats cut-through until that packet ends.
        if ((PKT_MODE != 0) && full && (pkt_q == '0)) begin
            flush_d = 1'b1;
            ovf_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            pkt_q    <= '0;
            flush_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            pkt_q    <= pkt_d;
            flush_q  <= flush_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// tb_axis_pkt_fifo
//   Three FIFO instances (cut-through D16, packet D16, packet D8) share one
//   input stream; each is compared every cycle against a queue-based model.
module tb_axis_pkt_fifo;
    import axis_fifo_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_vld;
    logic [7:0] s_dat;
    logic       s_lst;
    logic       m_rdy;

    logic       s_rdy [3];
    logic       m_vld [3];
    logic [7:0] m_dat [3];
    logic       m_lst [3];
    logic       ovf   [3];
    logic [4:0] lvl0, lvl1, pk0, pk1;
    logic [3:0] lvl2, pk2;

    int total = 0;
    int bad   = 0;

    typedef axis_entry_t q_t[$];
    q_t mq [3];
    bit mflush [3];
    bit movf   [3];
    bit e_rdy  [3];
    bit e_vld  [3];

    always #5 clk = ~clk;

    axis_pkt_fifo #(.WIDTH(8), .DEPTH(16), .PKT_MODE(0)) u_d0 (
        .clk(clk), .rst(rst),
        .S_AXIS_TVALID(s_vld), .S_AXIS_TREADY(s_rdy[0]), .S_AXIS_TDATA(s_dat), .S_AXIS_TLAST(s_lst),
        .M_AXIS_TVALID(m_vld[0]), .M_AXIS_TREADY(m_rdy), .M_AXIS_TDATA(m_dat[0]), .M_AXIS_TLAST(m_lst[0]),
        .level(lvl0), .pkt_count(pk0), .oversize_err(ovf[0])
    );

    axis_pkt_fifo #(.WIDTH(8), .DEPTH(16), .PKT_MODE(1)) u_d1 (
        .clk(clk), .rst(rst),
        .S_AXIS_TVALID(s_vld), .S_AXIS_TREADY(s_rdy[1]), .S_AXIS_TDATA(s_dat), .S_AXIS_TLAST(s_lst),
        .M_AXIS_TVALID(m_vld[1]), .M_AXIS_TREADY(m_rdy), .M_AXIS_TDATA(m_dat[1]), .M_AXIS_TLAST(m_lst[1]),
        .level(lvl1), .pkt_count(pk1), .oversize_err(ovf[1])
    );

    axis_pkt_fifo #(.WIDTH(8), .DEPTH(8), .PKT_MODE(1)) u_d2 (
        .clk(clk), .rst(rst),
        .S_AXIS_TVALID(s_vld), .S_AXIS_TREADY(s_rdy[2]), .S_AXIS_TDATA(s_dat), .S_AXIS_TLAST(s_lst),
        .M_AXIS_TVALID(m_vld[2]), .M_AXIS_TREADY(m_rdy), .M_AXIS_TDATA(m_dat[2]), .M_AXIS_TLAST(m_lst[2]),
        .level(lvl2), .pkt_count(pk2), .oversize_err(ovf[2])
    );

    function automatic int dep(int k);
        return (k == 2) ? 8 : 16;
    endfunction

    function automatic int pmode(int k);
        return (k == 0) ? 0 : 1;
    endfunction

    function automatic int npk(int k);
        int n = 0;
        foreach (mq[k][i]) if (mq[k][i].tlast) n++;
        return n;
    endfunction

    function automatic logic [31:0] obs_lvl(int k);
        case (k)
            0:       return 32'(lvl0);
            1:       return 32'(lvl1);
            default: return 32'(lvl2);
        endcase
    endfunction

    function automatic logic [31:0] obs_pk(int k);
        case (k)
            0:       return 32'(pk0);
            1:       return 32'(pk1);
            default: return 32'(pk2);
        endcase
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[dut%0d]: observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    // Called just after a negedge with inputs already applied: checks the
    // outputs, advances the models across the next posedge, returns at the
    // following negedge.
    task automatic cycle();
        #1;
        for (int k = 0; k < 3; k++) begin
            int sz;
            int pk;
            sz = mq[k].size();
            pk = npk(k);
            e_rdy[k] = (sz < dep(k));
            e_vld[k] = (sz != 0) && (pmode(k) == 0 || pk != 0 || mflush[k]);
            chk("s_tready", k, 32'(s_rdy[k]), 32'(e_rdy[k]));
            chk("m_tvalid", k, 32'(m_vld[k]), 32'(e_vld[k]));
            chk("level", k, obs_lvl(k), 32'(sz));
            chk("pkt_count", k, obs_pk(k), 32'(pk));
            chk("oversize_err", k, 32'(ovf[k]), 32'(movf[k]));
            if (e_vld[k]) begin
                chk("m_tdata", k, 32'(m_dat[k]), 32'(mq[k][0].tdata));
                chk("m_tlast", k, 32'(m_lst[k]), 32'(mq[k][0].tlast));
            end
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            int sz;
            int pk;
            bit set_fl;
            axis_entry_t head;
            axis_entry_t beat;
            sz = mq[k].size();
            pk = npk(k);
            set_fl = (pmode(k) != 0) && (sz == dep(k)) && (pk == 0);
            if (rst) begin
                mq[k].delete();
                mflush[k] = 1'b0;
                movf[k]   = 1'b0;
            end else begin
                if (e_vld[k] && m_rdy) begin
                    head = mq[k].pop_front();
                    if (head.tlast) mflush[k] = 1'b0;
                end
                if (s_vld && e_rdy[k]) begin
                    beat.tlast = s_lst;
                    beat.tdata = s_dat;
                    mq[k].push_back(beat);
                end
                if (set_fl) begin
                    mflush[k] = 1'b1;
                    movf[k]   = 1'b1;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [7:0] d, input bit l, input bit r);
        s_vld = v;
        s_dat = d;
        s_lst = l;
        m_rdy = r;
        cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        s_vld = 1'b0;
        s_dat = '0;
        s_lst = 1'b0;
        m_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mflush[k] = 1'b0;
            movf[k]   = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state, then five beats buffered and drained in order.
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) drive(1'b1, 8'(i), (i == 5), 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (7) drive(1'b0, 8'h00, 1'b0, 1'b1);

        // Fill to full, then a held 17th beat while the read side opens.
        do_reset();
        for (int i = 0; i < 16; i++) drive(1'b1, 8'(8'h10 + i), (i == 15), 1'b0);
        drive(1'b1, 8'h20, 1'b1, 1'b0);
        drive(1'b1, 8'h20, 1'b1, 1'b1);
        drive(1'b1, 8'h20, 1'b1, 1'b1);
        repeat (20) drive(1'b0, 8'h00, 1'b0, 1'b1);

        // Continuous streaming across pointer wrap.
        do_reset();
        for (int i = 0; i < 40; i++) drive(1'b1, 8'(8'h40 + i), (i % 4 == 3), 1'b1);
        repeat (20) drive(1'b0, 8'h00, 1'b0, 1'b1);

        // Short packet with ready held high.
        do_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'h30 + i), (i == 2), 1'b1);
        repeat (5) drive(1'b0, 8'h00, 1'b0, 1'b1);

        // Ten-beat packet overflowing the DEPTH=8 packet-mode instance.
        do_reset();
        for (int i = 0; i < 8; i++) drive(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        drive(1'b1, 8'h88, 1'b0, 1'b0);
        drive(1'b1, 8'h88, 1'b0, 1'b1);
        drive(1'b1, 8'h88, 1'b0, 1'b1);
        drive(1'b1, 8'h89, 1'b1, 1'b1);
        repeat (15) drive(1'b0, 8'h00, 1'b0, 1'b1);

        // Reset in the middle of a packet, then a fresh packet.
        do_reset();
        for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'hA0 + i), (i == 2), 1'b0);
        repeat (10) drive(1'b0, 8'h00, 1'b0, 1'b1);

        // Random traffic: a congested phase, a reset, a free-flowing phase.
        do_reset();
        for (int i = 0; i < 300; i++)
            drive(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 3) == 0));
        do_reset();
        for (int i = 0; i < 300; i++)
            drive(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 3) != 0));
        repeat (20) drive(1'b0, 8'h00, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
